// File: rtl/ps2_digit_tx.sv
// Device-side PS/2 transmitter: turns a decimal digit into its Set-2 scancode and
// clocks it out as an 11-bit frame (optionally make, F0, make).
module ps2_digit_tx #(
    parameter int HALF_CLKS  = 5,
    parameter int GAP_CLKS   = 20,
    parameter int SEND_BREAK = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] digit_i,
    input  logic       send_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic       ps2_clk_o,
    output logic       ps2_data_o
);

    localparam int CNT_MAX = (HALF_CLKS > GAP_CLKS) ? HALF_CLKS : GAP_CLKS;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CLKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CLKS - 1);
    localparam logic [1:0]       LAST_FRAME = (SEND_BREAK != 0) ? 2'd2 : 2'd0;
    localparam logic [3:0]       LAST_BIT   = 4'd10;

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_GAP} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       bit_idx, bit_n;
    logic [1:0]       frame_idx, frame_n;
    logic [7:0]       code, code_n;
    logic             busy_n, done_n, err_n, clk_n, data_n;
    logic [7:0]       cur_byte;

    function automatic logic [7:0] scancode(input logic [3:0] d);
        case (d)
            4'd0:    scancode = 8'h45;
            4'd1:    scancode = 8'h16;
            4'd2:    scancode = 8'h1E;
            4'd3:    scancode = 8'h26;
            4'd4:    scancode = 8'h25;
            4'd5:    scancode = 8'h2E;
            4'd6:    scancode = 8'h36;
            4'd7:    scancode = 8'h3D;
            4'd8:    scancode = 8'h3E;
            default: scancode = 8'h46;
        endcase
    endfunction

    // Bit 0 is the start bit, bits 1..8 the byte LSB first, bit 9 odd parity, bit 10 stop.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        logic [10:0] f;
        f = {1'b1, ~^b, b, 1'b0};
        frame_bit = (idx <= LAST_BIT) ? f[idx] : 1'b1;
    endfunction

    // The middle frame of a make/break sequence is the F0 prefix.
    assign cur_byte = (frame_idx == 2'd1) ? 8'hF0 : code;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        frame_n = frame_idx;
        code_n  = code;
        busy_n  = busy_o;
        done_n  = 1'b0;
        err_n   = 1'b0;
        clk_n   = ps2_clk_o;
        data_n  = ps2_data_o;
        case (state)
            S_IDLE: begin
                clk_n  = 1'b1;
                data_n = 1'b1;
                if (send_i) begin
                    if (digit_i <= 4'd9) begin
                        code_n  = scancode(digit_i);
                        state_n = S_HIGH;
                        cnt_n   = '0;
                        bit_n   = '0;
                        frame_n = '0;
                        busy_n  = 1'b1;
                        data_n  = 1'b0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            S_HIGH: begin
                if (cnt == HALF_LAST) begin
                    state_n = S_LOW;
                    cnt_n   = '0;
                    clk_n   = 1'b0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_LOW: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    clk_n = 1'b1;
                    if (bit_idx < LAST_BIT) begin
                        bit_n   = bit_idx + 4'd1;
                        state_n = S_HIGH;
                        data_n  = frame_bit(cur_byte, bit_idx + 4'd1);
                    end else if (frame_idx != LAST_FRAME) begin
                        frame_n = frame_idx + 2'd1;
                        state_n = S_GAP;
                        data_n  = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                        data_n  = 1'b1;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                clk_n  = 1'b1;
                data_n = 1'b1;
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = S_HIGH;
                    data_n  = 1'b0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            frame_idx  <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            ps2_clk_o  <= 1'b1;
            ps2_data_o <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_n;
            frame_idx  <= frame_n;
            busy_o     <= busy_n;
            done_o     <= done_n;
            err_o      <= err_n;
            ps2_clk_o  <= clk_n;
            ps2_data_o <= data_n;
        end
    end

    // The latched scancode is only read while busy, so it needs no reset.
    always_ff @(posedge clk_i) begin
        code <= code_n;
    end

endmodule
